// File: rtl/ay_pkg.sv
// Shared definitions for the AY-3-891x bus master.
// Contents: register address map, request field widths, the packed request
// record {rw, addr, data} carried through the request FIFO, and the bus FSM
// state encoding.
package ay_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W;

    // AY register file map
    localparam logic [ADDR_W-1:0] AY_TONE_A_LO = 4'd0;
    localparam logic [ADDR_W-1:0] AY_TONE_A_HI = 4'd1;
    localparam logic [ADDR_W-1:0] AY_TONE_B_LO = 4'd2;
    localparam logic [ADDR_W-1:0] AY_TONE_B_HI = 4'd3;
    localparam logic [ADDR_W-1:0] AY_TONE_C_LO = 4'd4;
    localparam logic [ADDR_W-1:0] AY_TONE_C_HI = 4'd5;
    localparam logic [ADDR_W-1:0] AY_NOISE_PER = 4'd6;
    localparam logic [ADDR_W-1:0] AY_MIXER     = 4'd7;
    localparam logic [ADDR_W-1:0] AY_AMP_A     = 4'd8;
    localparam logic [ADDR_W-1:0] AY_AMP_B     = 4'd9;
    localparam logic [ADDR_W-1:0] AY_AMP_C     = 4'd10;
    localparam logic [ADDR_W-1:0] AY_ENV_LO    = 4'd11;
    localparam logic [ADDR_W-1:0] AY_ENV_HI    = 4'd12;
    localparam logic [ADDR_W-1:0] AY_ENV_SHAPE = 4'd13;

    // One queued host request: rw=1 is a read, data is ignored for reads.
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ay_req_t;

    // Bus FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_RDWAIT = 3'd3;
    localparam logic [2:0] ST_GAPW   = 3'd4;

endpackage

// File: rtl/ay_req_fifo.sv
// Synchronous request FIFO for the AY bus master.
// Ports:
//   clk, reset      - clock, synchronous active-low reset (empties the queue)
//   push, push_data - write an entry (ignored while full)
//   pop, pop_data   - pop_data always shows the head; pop removes it
//                     (ignored while empty)
//   full, empty     - decoded from the registered occupancy count
//   count           - number of valid entries, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module ay_req_fifo
    import ay_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = REQ_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count define which
    // entries are valid, so clearing the array would be wasted logic.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leave the count unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ay_bus_master.sv
// AY-3-891x register bus initiator.
// Host requests enter a FIFO through a valid/ready port; each is serialised
// into an address-latch phase (a0=0, wr_tick, wdata=register number) and a
// data phase (a0=1, wr_tick with the data byte, or rd_tick for a read).
// Read data is sampled RD_LATENCY cycles after rd_tick and returned on a
// one-cycle rsp_valid strobe. GAP idle cycles follow every transaction.
// Ports:
//   clk, reset                  - clock, synchronous active-low reset
//   req_valid/req_ready         - request handshake
//   req_rw, req_addr, req_data  - 0=write/1=read, register number, write data
//   rsp_valid, rsp_data         - read response strobe, data held until next
//   busy                        - queue not empty or a transaction in flight
//   a0, wr_tick, rd_tick, wdata - registered AY bus outputs
//   rdata                       - read data from the register file
module ay_bus_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP        = 0,
    parameter int RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       a0,
    output logic       wr_tick,
    output logic       rd_tick,
    output logic [7:0] wdata,
    input  logic [7:0] rdata
);

    import ay_pkg::*;

    localparam int         CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] RD_LAT_L = RD_LATENCY[1:0];
    localparam logic [3:0] GAP_L    = GAP[3:0];
    localparam bit         GAP_EN   = (GAP != 0);

    logic [2:0]       state;
    logic [2:0]       chain_state;
    ay_req_t          cur;
    ay_req_t          head;
    logic [3:0]       gap_cnt;
    logic [1:0]       lat_cnt;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             txn_done;
    logic             rd_sample;
    logic             gap_done;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && !fifo_full;
    assign busy      = (fifo_count != '0) || (state != ST_IDLE);

    ay_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({req_rw, req_addr, req_data}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rd_sample = (state == ST_RDWAIT) && (lat_cnt == RD_LAT_L);
    assign txn_done  = ((state == ST_DATA) && !cur.rw) || rd_sample;
    assign gap_done  = (state == ST_GAPW) && (gap_cnt == GAP_L);

    // Where the FSM goes from a point where a new request may start: IDLE,
    // end of a transaction, or end of the gap. Chaining straight into ADDR
    // (popping the head) keeps writes back to back and makes the gap exactly
    // GAP cycles rather than GAP plus an IDLE cycle.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        chain_state = ST_IDLE;
        fifo_pop    = 1'b0;
        if (txn_done && GAP_EN) begin
            chain_state = ST_GAPW;
        end else if ((txn_done || gap_done || state == ST_IDLE) && !fifo_empty) begin
            chain_state = ST_ADDR;
            fifo_pop    = 1'b1;
        end
    end

    // Bus outputs are registered from the current state, so each phase shows
    // on the bus in the cycle after the FSM is in that state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cur       <= '0;
            gap_cnt   <= '0;
            lat_cnt   <= '0;
            a0        <= 1'b0;
            wr_tick   <= 1'b0;
            rd_tick   <= 1'b0;
            wdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            a0        <= 1'b0;
            wr_tick   <= 1'b0;
            rd_tick   <= 1'b0;
            wdata     <= '0;
            rsp_valid <= 1'b0;

            if (fifo_pop) begin
                cur <= head;
            end

            case (state)
                ST_IDLE: begin
                    state <= chain_state;
                end
                ST_ADDR: begin
                    wr_tick <= 1'b1;
                    wdata   <= {{(DATA_W - ADDR_W){1'b0}}, cur.addr};
                    state   <= ST_DATA;
                end
                ST_DATA: begin
                    a0 <= 1'b1;
                    if (cur.rw) begin
                        rd_tick <= 1'b1;
                        lat_cnt <= 2'd1;
                        state   <= ST_RDWAIT;
                    end else begin
                        wr_tick <= 1'b1;
                        wdata   <= cur.data;
                        gap_cnt <= 4'd1;
                        state   <= chain_state;
                    end
                end
                ST_RDWAIT: begin
                    // lat_cnt==1 is the cycle rd_tick is on the bus.
                    if (rd_sample) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= rdata;
                        gap_cnt   <= 4'd1;
                        state     <= chain_state;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                ST_GAPW: begin
                    if (gap_done) begin
                        state <= chain_state;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ay_bus_master.sv
// Directed bench for ay_bus_master: one instance with GAP=0 and one with
// GAP=3, each attached to a small behavioural AY register file.
module tb_ay_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Instance 0: GAP=0, RD_LATENCY=1
    logic       reset0, req_valid0, req_ready0, req_rw0;
    logic [3:0] req_addr0;
    logic [7:0] req_data0, rsp_data0, wdata0, rdata0;
    logic       rsp_valid0, busy0, a0_0, wr_tick0, rd_tick0;

    // Instance 1: GAP=3, RD_LATENCY=1
    logic       reset1, req_valid1, req_ready1, req_rw1;
    logic [3:0] req_addr1;
    logic [7:0] req_data1, rsp_data1, wdata1, rdata1;
    logic       rsp_valid1, busy1, a0_1, wr_tick1, rd_tick1;

    ay_bus_master #(.FIFO_DEPTH(4), .GAP(0), .RD_LATENCY(1)) u_dut0 (
        .clk(clk), .reset(reset0), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_rw(req_rw0), .req_addr(req_addr0), .req_data(req_data0),
        .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .busy(busy0),
        .a0(a0_0), .wr_tick(wr_tick0), .rd_tick(rd_tick0), .wdata(wdata0), .rdata(rdata0)
    );

    ay_bus_master #(.FIFO_DEPTH(4), .GAP(3), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset1), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_rw(req_rw1), .req_addr(req_addr1), .req_data(req_data1),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .busy(busy1),
        .a0(a0_1), .wr_tick(wr_tick1), .rd_tick(rd_tick1), .wdata(wdata1), .rdata(rdata1)
    );

    // Behavioural AY register files: a0=0 write latches the register
    // number, a0=1 write stores data, rdata shows the latched register.
    logic [7:0] regs0 [16];
    logic [7:0] regs1 [16];
    logic [3:0] lat0 = 4'd0;
    logic [3:0] lat1 = 4'd0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            regs0[i] = 8'h00;
            regs1[i] = 8'h00;
        end
    end

    always @(posedge clk) begin
        if (wr_tick0 === 1'b1) begin
            if (a0_0) regs0[lat0] <= wdata0;
            else      lat0 <= wdata0[3:0];
        end
        if (wr_tick1 === 1'b1) begin
            if (a0_1) regs1[lat1] <= wdata1;
            else      lat1 <= wdata1[3:0];
        end
    end

    assign rdata0 = regs0[lat0];
    assign rdata1 = regs1[lat1];

    // Bus monitors
    typedef struct {
        int         cyc;
        logic       a0;
        logic       wr;
        logic       rd;
        logic [7:0] wd;
    } tick_t;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } rsp_t;

    tick_t tq0[$];
    tick_t tq1[$];
    rsp_t  rq0[$];
    logic  saw_full1 = 1'b0;

    always @(negedge clk) begin : mon
        tick_t t;
        rsp_t  r;
        if (wr_tick0 === 1'b1 || rd_tick0 === 1'b1) begin
            t.cyc = cyc; t.a0 = a0_0; t.wr = wr_tick0; t.rd = rd_tick0; t.wd = wdata0;
            tq0.push_back(t);
        end
        if (wr_tick1 === 1'b1 || rd_tick1 === 1'b1) begin
            t.cyc = cyc; t.a0 = a0_1; t.wr = wr_tick1; t.rd = rd_tick1; t.wd = wdata1;
            tq1.push_back(t);
        end
        if (rsp_valid0 === 1'b1) begin
            r.cyc = cyc; r.d = rsp_data0;
            rq0.push_back(r);
        end
    end

    always @(posedge clk) begin
        if (req_valid1 === 1'b1 && req_ready1 === 1'b0) saw_full1 <= 1'b1;
    end

    // Stimulus helpers
    task automatic send0(input logic rw, input logic [3:0] addr, input logic [7:0] data);
        int n = 0;
        @(negedge clk);
        req_valid0 = 1'b1; req_rw0 = rw; req_addr0 = addr; req_data0 = data;
        while (req_ready0 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) begin
            total_cnt++;
            $display("FAIL send0_timeout: req_ready=%b required 1", req_ready0);
        end
        @(posedge clk);
        #1 req_valid0 = 1'b0;
    endtask

    task automatic send1(input logic rw, input logic [3:0] addr, input logic [7:0] data);
        int n = 0;
        @(negedge clk);
        req_valid1 = 1'b1; req_rw1 = rw; req_addr1 = addr; req_data1 = data;
        while (req_ready1 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) begin
            total_cnt++;
            $display("FAIL send1_timeout: req_ready=%b required 1", req_ready1);
        end
        @(posedge clk);
        #1 req_valid1 = 1'b0;
    endtask

    task automatic wait_idle0();
        int n = 0;
        @(negedge clk);
        while (busy0 !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) begin
            total_cnt++;
            $display("FAIL idle0_timeout: busy=%b required 0", busy0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle1();
        int n = 0;
        @(negedge clk);
        while (busy1 !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) begin
            total_cnt++;
            $display("FAIL idle1_timeout: busy=%b required 0", busy1);
        end
        repeat (3) @(negedge clk);
    endtask

    // Tests
    task automatic test_reset();
        logic [21:0] got;
        reset0 = 1'b0; reset1 = 1'b0;
        req_valid0 = 1'b0; req_rw0 = 1'b0; req_addr0 = '0; req_data0 = '0;
        req_valid1 = 1'b0; req_rw1 = 1'b0; req_addr1 = '0; req_data1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // {a0, wr, rd, wdata, rsp_valid, rsp_data, busy, req_ready}
        got = {a0_0, wr_tick0, rd_tick0, wdata0, rsp_valid0, rsp_data0, busy0, req_ready0};
        total_cnt++;
        if (got !== 22'h000001) $display("FAIL reset_outputs0: got %h required %h", got, 22'h000001);
        else pass_cnt++;
        got = {a0_1, wr_tick1, rd_tick1, wdata1, rsp_valid1, rsp_data1, busy1, req_ready1};
        total_cnt++;
        if (got !== 22'h000001) $display("FAIL reset_outputs1: got %h required %h", got, 22'h000001);
        else pass_cnt++;
        reset0 = 1'b1; reset1 = 1'b1;
    endtask

    task automatic test_single_write();
        logic [2:0]  st;
        logic [10:0] bus;
        send0(1'b0, 4'd1, 8'h0f);                  // accepted at edge N
        @(negedge clk);                            // after N
        st = {busy0, wr_tick0, rd_tick0};
        total_cnt++;
        if (st !== 3'b100) $display("FAIL single_n1 busy/wr/rd: got %b required 100", st);
        else pass_cnt++;
        @(negedge clk);                            // after N+1
        st = {busy0, wr_tick0, rd_tick0};
        total_cnt++;
        if (st !== 3'b100) $display("FAIL single_n2 busy/wr/rd: got %b required 100", st);
        else pass_cnt++;
        @(negedge clk);                            // after N+2: address phase
        bus = {a0_0, wr_tick0, rd_tick0, wdata0};
        total_cnt++;
        if (bus !== {3'b010, 8'h01}) $display("FAIL single_addr a0/wr/rd/wdata: got %h required %h", bus, {3'b010, 8'h01});
        else pass_cnt++;
        @(negedge clk);                            // data phase
        bus = {a0_0, wr_tick0, rd_tick0, wdata0};
        total_cnt++;
        if (bus !== {3'b110, 8'h0f}) $display("FAIL single_data a0/wr/rd/wdata: got %h required %h", bus, {3'b110, 8'h0f});
        else pass_cnt++;
        @(negedge clk);
        bus = {a0_0, wr_tick0, rd_tick0, wdata0};
        total_cnt++;
        if ({bus, busy0} !== 12'h000) $display("FAIL single_idle bus+busy: got %h required 000", {bus, busy0});
        else pass_cnt++;
        total_cnt++;
        if (regs0[1] !== 8'h0f) $display("FAIL single_reg1: got %h required 0f", regs0[1]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  exp_wd [8];
        logic [10:0] got;
        logic [10:0] exp;
        exp_wd = '{8'h00, 8'h21, 8'h01, 8'h0f, 8'h08, 8'h0f, 8'h07, 8'h07};
        tq0.delete();
        send0(1'b0, 4'd0, 8'h21);
        send0(1'b0, 4'd1, 8'h0f);
        send0(1'b0, 4'd8, 8'h0f);
        send0(1'b0, 4'd7, 8'h07);
        wait_idle0();
        total_cnt++;
        if (tq0.size() != 8) $display("FAIL burst_tick_count: got %0d required 8", tq0.size());
        else pass_cnt++;
        if (tq0.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                got = {tq0[i].a0, tq0[i].wr, tq0[i].rd, tq0[i].wd};
                exp = {i[0], 1'b1, 1'b0, exp_wd[i]};
                total_cnt++;
                if (got !== exp || tq0[i].cyc != tq0[0].cyc + i)
                    $display("FAIL burst_tick[%0d]: got %h at +%0d required %h at +%0d",
                             i, got, tq0[i].cyc - tq0[0].cyc, exp, i);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({regs0[0], regs0[1], regs0[8], regs0[7]} !== 32'h210f0f07)
            $display("FAIL burst_regs r0/r1/r8/r7: got %h required 210f0f07", {regs0[0], regs0[1], regs0[8], regs0[7]});
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        logic [10:0] got;
        tq0.delete();
        rq0.delete();
        send0(1'b0, 4'd11, 8'he1);
        send0(1'b1, 4'd11, 8'h55);               // data byte is ignored for reads
        wait_idle0();
        total_cnt++;
        if (tq0.size() != 4) $display("FAIL rd_tick_count: got %0d required 4", tq0.size());
        else pass_cnt++;
        total_cnt++;
        if (rq0.size() != 1) $display("FAIL rd_rsp_pulses: got %0d required 1", rq0.size());
        else pass_cnt++;
        if (tq0.size() == 4 && rq0.size() == 1) begin
            got = {tq0[2].a0, tq0[2].wr, tq0[2].rd, tq0[2].wd};
            total_cnt++;
            if (got !== {3'b010, 8'h0b}) $display("FAIL rd_addr_phase: got %h required %h", got, {3'b010, 8'h0b});
            else pass_cnt++;
            got = {tq0[3].a0, tq0[3].wr, tq0[3].rd, tq0[3].wd};
            total_cnt++;
            if (got !== {3'b101, 8'h00}) $display("FAIL rd_data_phase: got %h required %h", got, {3'b101, 8'h00});
            else pass_cnt++;
            total_cnt++;
            if (rq0[0].cyc != tq0[3].cyc + 1) $display("FAIL rd_latency: got %0d required 1", rq0[0].cyc - tq0[3].cyc);
            else pass_cnt++;
            total_cnt++;
            if (rq0[0].d !== 8'he1) $display("FAIL rd_data: got %h required e1", rq0[0].d);
            else pass_cnt++;
        end
        total_cnt++;
        if (rsp_data0 !== 8'he1) $display("FAIL rd_data_held: got %h required e1", rsp_data0);
        else pass_cnt++;
    endtask

    task automatic test_fifo_full();
        logic [17:0] got;
        logic [17:0] exp;
        tq1.delete();
        saw_full1 = 1'b0;
        for (int i = 0; i < 6; i++) send1(1'b0, 4'(i + 2), 8'(8'h30 + i));
        wait_idle1();
        total_cnt++;
        if (saw_full1 !== 1'b1) $display("FAIL full_ready_low: got %b required 1", saw_full1);
        else pass_cnt++;
        total_cnt++;
        if (tq1.size() != 12) $display("FAIL full_tick_count: got %0d required 12", tq1.size());
        else pass_cnt++;
        if (tq1.size() == 12) begin
            for (int i = 0; i < 6; i++) begin
                got = {tq1[2*i].a0, tq1[2*i].wd, tq1[2*i+1].a0, tq1[2*i+1].wd};
                exp = {1'b0, 4'h0, 4'(i + 2), 1'b1, 8'(8'h30 + i)};
                total_cnt++;
                if (got !== exp) $display("FAIL full_order[%0d]: got %h required %h", i, got, exp);
                else pass_cnt++;
            end
            for (int i = 0; i < 5; i++) begin
                total_cnt++;
                if (tq1[2*i+2].cyc - tq1[2*i+1].cyc != 4)
                    $display("FAIL full_gap[%0d]: got %0d required 4", i, tq1[2*i+2].cyc - tq1[2*i+1].cyc);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_gap();
        tq1.delete();
        send1(1'b0, 4'd4, 8'h5c);
        send1(1'b0, 4'd5, 8'ha3);
        wait_idle1();
        total_cnt++;
        if (tq1.size() != 4) $display("FAIL gap_tick_count: got %0d required 4", tq1.size());
        else pass_cnt++;
        if (tq1.size() == 4) begin
            // DATA of the first write and ADDR of the second are 4 cycles
            // apart: three idle bus cycles between them.
            total_cnt++;
            if (tq1[2].cyc - tq1[1].cyc != 4) $display("FAIL gap_idle: got %0d required 4", tq1[2].cyc - tq1[1].cyc);
            else pass_cnt++;
            total_cnt++;
            if (tq1[3].cyc - tq1[2].cyc != 1) $display("FAIL gap_addr_to_data: got %0d required 1", tq1[3].cyc - tq1[2].cyc);
            else pass_cnt++;
        end
        total_cnt++;
        if ({regs1[4], regs1[5]} !== 16'h5ca3) $display("FAIL gap_regs: got %h required 5ca3", {regs1[4], regs1[5]});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        int          n = 0;
        logic [21:0] got;
        rq0.delete();
        send0(1'b1, 4'd11, 8'h00);
        @(negedge clk);
        while (rd_tick0 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (n == 20) $display("FAIL midrst_rd_tick_seen: got 0 required 1");
        else pass_cnt++;
        reset0 = 1'b0;                             // applied on the next edge
        @(negedge clk);
        got = {a0_0, wr_tick0, rd_tick0, wdata0, rsp_valid0, rsp_data0, busy0, req_ready0};
        total_cnt++;
        if (got !== 22'h000001) $display("FAIL midrst_outputs: got %h required %h", got, 22'h000001);
        else pass_cnt++;
        reset0 = 1'b1;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (rq0.size() != 0) $display("FAIL midrst_no_rsp: got %0d pulses required 0", rq0.size());
        else pass_cnt++;
        tq0.delete();
        send0(1'b0, 4'd3, 8'h5a);
        wait_idle0();
        total_cnt++;
        if (tq0.size() != 2) $display("FAIL midrst_new_write_ticks: got %0d required 2", tq0.size());
        else pass_cnt++;
        total_cnt++;
        if (regs0[3] !== 8'h5a) $display("FAIL midrst_new_write_reg3: got %h required 5a", regs0[3]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_write_read();
        test_fifo_full();
        test_gap();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
